fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It consumes the redirect produced by branch resolution (taken flag plus target PC), the stall from the hazard unit, and halt detection on fetched instructions. It drives the instruction-memory address and presents the fetched instruction with its PC+2 to decode.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_carry_lookahead.sv | 55 +++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC   = 16'h0000;
    localparam logic [3:0]         HLT_OPCODE = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;
    localparam logic [PC_W-1:0]    PC_INCR    = 16'h0002;

    typedef enum logic {
        StRun  = 1'b0,
        StHold = 1'b1
    } fetch_state_e;

    // True when the fetched word is a halt instruction.
    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return instr[15:12] == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_unit_carry_lookahead.sv
// 16-bit adder/subtractor: 4-bit groups with lookahead across groups,
// ripple inside each group. overflow_o is signed overflow.
module fetch_unit_carry_lookahead (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] sum_o,
    output logic        overflow_o
);

    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [16:0] c;

    // Generate/propagate, group lookahead, then in-group carries and sum.
    always_comb begin
        b_eff = b_i ^ {16{sub_i}};
        g     = a_i & b_eff;
        p     = a_i ^ b_eff;
        grp_g = '0;
        grp_p = '0;
        c     = '0;

        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end

        // Group carry-ins, fully expanded so they do not ripple group to group.
        c[0]  = sub_i;
        c[4]  = grp_g[0] | (grp_p[0] & c[0]);
        c[8]  = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c[0]);
        c[12] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[2] & grp_p[1] & grp_p[0] & c[0]);
        c[16] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c[0]);

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end

        sum_o      = p ^ c[15:0];
        overflow_o = c[15] ^ c[16];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, handles
// redirect, stall and halt-on-HLT.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        fetch_held
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ifid_instr_q, ifid_instr_d;
    logic [15:0]  ifid_pc_plus2_q, ifid_pc_plus2_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [15:0]  pc_plus2;
    logic         unused_pc_ovf;
    logic         unused_redirect_lsb;

    // Targets are halfword aligned; bit 0 of the redirect is dropped.
    assign unused_redirect_lsb = redirect_pc[0];

    fetch_unit_carry_lookahead u_pc_adder (
        .a_i        (pc_q),
        .b_i        (PC_INCR),
        .sub_i      (1'b0),
        .sum_o      (pc_plus2),
        .overflow_o (unused_pc_ovf)
    );

    // Next-state: redirect beats stall, stall beats the per-state action.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus2_d = ifid_pc_plus2_q;
        ifid_valid_d    = ifid_valid_q;

        if (redirect) begin
            pc_d         = {redirect_pc[15:1], 1'b0};
            state_d      = StRun;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                StRun: begin
                    ifid_instr_d    = imem_data;
                    ifid_pc_plus2_d = pc_plus2;
                    ifid_valid_d    = 1'b1;
                    if (is_hlt(imem_data)) begin
                        state_d = StHold;
                    end else begin
                        pc_d = {pc_plus2[15:1], 1'b0};
                    end
                end
                StHold: begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // All fetch-stage state, synchronous reset first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            pc_q            <= RESET_PC;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus2_q <= 16'h0000;
            ifid_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus2_q <= ifid_pc_plus2_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc_plus2 = ifid_pc_plus2_q;
    assign ifid_valid    = ifid_valid_q;
    assign fetch_held    = (state_q == StHold);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Each check compares the packed outputs
// {imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_held}.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        fetch_held;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .fetch_held    (fetch_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 1234 everywhere, HLT at 0x0010, marker at 0x0040.
    always_comb begin
        imem_data = 16'h1234;
        if (imem_addr == 16'h0010) imem_data = 16'hF000;
        if (imem_addr == 16'h0040) imem_data = 16'h5A40;
    end

    logic [49:0] obs;
    assign obs = {imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_held};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        step();
        step();
        n_tests++;
        if (obs !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", obs, {16'h0000, 16'h0000, 16'h0000, 2'b00});
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [15:0] exp_pc;
        n_tests++;
        if (imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL free_run_addr0: got %h want 0000", imem_addr);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_pc = 16'(2 * i);
            n_tests++;
            if (obs !== {exp_pc, 16'h1234, exp_pc, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL free_run_%0d: got %h want %h", i, obs,
                         {exp_pc, 16'h1234, exp_pc, 2'b10});
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs !== {16'h0008, 16'h1234, 16'h0008, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, obs,
                         {16'h0008, 16'h1234, 16'h0008, 2'b10});
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (obs !== {16'h000A, 16'h1234, 16'h000A, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_resume: got %h want %h", obs,
                     {16'h000A, 16'h1234, 16'h000A, 2'b10});
        end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0041;
        step();
        n_tests++;
        if (obs !== {16'h0040, 16'h0000, 16'h000A, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_flush: got %h want %h", obs,
                     {16'h0040, 16'h0000, 16'h000A, 2'b00});
        end
        stall = 1'b0; redirect = 1'b0;
        step();
        n_tests++;
        if (obs !== {16'h0042, 16'h5A40, 16'h0042, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_target: got %h want %h", obs,
                     {16'h0042, 16'h5A40, 16'h0042, 2'b10});
        end
    endtask

    task automatic test_halt();
        redirect = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        step();
        n_tests++;
        if (obs !== {16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_capture: got %h want %h", obs,
                     {16'h0010, 16'hF000, 16'h0012, 2'b11});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs !== {16'h0010, 16'h0000, 16'h0012, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL halt_bubble_%0d: got %h want %h", i, obs,
                         {16'h0010, 16'h0000, 16'h0012, 2'b01});
            end
        end
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        n_tests++;
        if (obs !== {16'h0100, 16'h0000, 16'h0012, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_release: got %h want %h", obs,
                     {16'h0100, 16'h0000, 16'h0012, 2'b00});
        end
        step();
        n_tests++;
        if (obs !== {16'h0102, 16'h1234, 16'h0102, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_resume: got %h want %h", obs,
                     {16'h0102, 16'h1234, 16'h0102, 2'b10});
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        n_tests++;
        if (imem_addr !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h want fffe", imem_addr);
        end
        step();
        n_tests++;
        if (obs !== {16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_next: got %h want %h", obs,
                     {16'h0000, 16'h1234, 16'h0000, 2'b10});
        end
    endtask

    task automatic test_reset_in_hold();
        redirect = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        step();
        n_tests++;
        if (fetch_held !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_entry: got %b want 1", fetch_held);
        end
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        n_tests++;
        if (obs !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_in_hold: got %h want %h", obs,
                     {16'h0000, 16'h0000, 16'h0000, 2'b00});
        end
        rst = 1'b0; redirect = 1'b0;
        step();
        n_tests++;
        if (obs !== {16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_then_run: got %h want %h", obs,
                     {16'h0002, 16'h1234, 16'h0002, 2'b10});
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_over_stall();
        test_halt();
        test_wrap();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
